// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, init table and command classification for lcd_ctrl
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_SETUP,
    ST_EN_HI,
    ST_HOLD,
    ST_EXEC
  } lcd_state_e;

  localparam int INIT_LEN = 4;
  // Entry 0 is issued first: function set, display on, clear, entry mode.
  localparam logic [INIT_LEN-1:0][7:0] INIT_CMDS = {8'h06, 8'h01, 8'h0C, 8'h38};

  localparam int LCD_ON_BIT = 31;
  localparam int LCD_RS_BIT = 9;

  // Clear and home commands need the long execution wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// rtl/lcd_timer.sv - loadable down-counter with zero flag, saturating at 0
module lcd_timer #(
  parameter int           W       = 20,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780 write engine: power-up init, 1-entry pending buffer, bus timing
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC = 4,
  parameter int EN_CYC    = 25,
  parameter int HOLD_CYC  = 2,
  parameter int EXEC_CYC  = 2500,
  parameter int CLR_CYC   = 82000,
  parameter int PWRUP_CYC = 750000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr,
  input  logic [31:0] i_lcd_reg,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic        o_drop
);

  localparam int TW = (PWRUP_CYC < 1) ? 1 : $clog2(PWRUP_CYC + 1);

  // A state lasting N cycles is entered with the timer at N-1; 0 behaves as 1.
  function automatic logic [TW-1:0] ld_val(input int n);
    return (n <= 1) ? '0 : TW'(n - 1);
  endfunction

  localparam logic [TW-1:0] SETUP_LD = ld_val(SETUP_CYC);
  localparam logic [TW-1:0] EN_LD    = ld_val(EN_CYC);
  localparam logic [TW-1:0] HOLD_LD  = ld_val(HOLD_CYC);
  localparam logic [TW-1:0] EXEC_LD  = ld_val(EXEC_CYC);
  localparam logic [TW-1:0] CLR_LD   = ld_val(CLR_CYC);
  localparam logic [TW-1:0] PWRUP_LD = ld_val(PWRUP_CYC);
  localparam logic [2:0]    INIT_END = 3'(INIT_LEN);

  lcd_state_e  state_q, state_d;
  logic        cmd_rs_q, cmd_rs_d;
  logic [7:0]  cmd_data_q, cmd_data_d;
  logic [2:0]  init_idx_q, init_idx_d;
  logic        pend_valid_q, pend_valid_d;
  logic        pend_rs_q, pend_rs_d;
  logic [7:0]  pend_data_q, pend_data_d;
  logic        on_q, on_d;
  logic        drop_q, drop_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_load_val;
  logic          tmr_zero;

  logic       wr_rs;
  logic [7:0] wr_data;
  logic       unused_reg_bits;

  assign wr_rs           = i_lcd_reg[LCD_RS_BIT];
  assign wr_data         = i_lcd_reg[7:0];
  assign unused_reg_bits = ^{i_lcd_reg[30:10], i_lcd_reg[8]};

  lcd_timer #(
    .W       (TW),
    .RST_VAL (PWRUP_LD)
  ) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (tmr_load),
    .i_load_val (tmr_load_val),
    .o_zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    cmd_rs_d     = cmd_rs_q;
    cmd_data_d   = cmd_data_q;
    init_idx_d   = init_idx_q;
    pend_valid_d = pend_valid_q;
    pend_rs_d    = pend_rs_q;
    pend_data_d  = pend_data_q;
    on_d         = i_wr ? i_lcd_reg[LCD_ON_BIT] : on_q;
    drop_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = SETUP_LD;

    case (state_q)
      ST_PWRUP: begin
        if (tmr_zero) begin
          state_d    = ST_SETUP;
          tmr_load   = 1'b1;
          cmd_rs_d   = 1'b0;
          cmd_data_d = INIT_CMDS[0];
          init_idx_d = 3'd1;
        end
      end
      ST_IDLE: begin
        if (i_wr) begin
          state_d    = ST_SETUP;
          tmr_load   = 1'b1;
          cmd_rs_d   = wr_rs;
          cmd_data_d = wr_data;
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_d      = ST_EN_HI;
          tmr_load     = 1'b1;
          tmr_load_val = EN_LD;
        end
      end
      ST_EN_HI: begin
        if (tmr_zero) begin
          state_d      = ST_HOLD;
          tmr_load     = 1'b1;
          tmr_load_val = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          state_d      = ST_EXEC;
          tmr_load     = 1'b1;
          tmr_load_val = is_slow_cmd(cmd_rs_q, cmd_data_q) ? CLR_LD : EXEC_LD;
        end
      end
      ST_EXEC: begin
        if (tmr_zero) begin
          if (init_idx_q != INIT_END) begin
            state_d    = ST_SETUP;
            tmr_load   = 1'b1;
            cmd_rs_d   = 1'b0;
            cmd_data_d = INIT_CMDS[init_idx_q[1:0]];
            init_idx_d = init_idx_q + 3'd1;
          end else if (pend_valid_q) begin
            state_d      = ST_SETUP;
            tmr_load     = 1'b1;
            cmd_rs_d     = pend_rs_q;
            cmd_data_d   = pend_data_q;
            pend_valid_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_PWRUP;
    endcase

    // Evaluated after any same-cycle consumption, so a freed slot is reused.
    if (i_wr && (state_q != ST_IDLE)) begin
      if (!pend_valid_d) begin
        pend_valid_d = 1'b1;
        pend_rs_d    = wr_rs;
        pend_data_d  = wr_data;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= ST_PWRUP;
      cmd_rs_q     <= 1'b0;
      cmd_data_q   <= 8'h00;
      init_idx_q   <= 3'd0;
      pend_valid_q <= 1'b0;
      pend_rs_q    <= 1'b0;
      pend_data_q  <= 8'h00;
      on_q         <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_rs_q     <= cmd_rs_d;
      cmd_data_q   <= cmd_data_d;
      init_idx_q   <= init_idx_d;
      pend_valid_q <= pend_valid_d;
      pend_rs_q    <= pend_rs_d;
      pend_data_q  <= pend_data_d;
      on_q         <= on_d;
      drop_q       <= drop_d;
    end
  end

  assign o_lcd_data = cmd_data_q;
  assign o_lcd_rs   = cmd_rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = (state_q == ST_EN_HI);
  assign o_lcd_on   = on_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_drop     = drop_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - directed bench for lcd_ctrl with shortened timing parameters
module tb_lcd_ctrl;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr    = 1'b0;
  logic [31:0] reg_v = 32'h0;
  logic [7:0]  data;
  logic        rs, rw, en, on, busy, drop;

  int n_cmp    = 0;
  int n_err    = 0;
  int drop_cnt = 0;

  always #5 clk = ~clk;

  lcd_ctrl #(
    .SETUP_CYC (2),
    .EN_CYC    (3),
    .HOLD_CYC  (1),
    .EXEC_CYC  (5),
    .CLR_CYC   (9),
    .PWRUP_CYC (10)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_wr       (wr),
    .i_lcd_reg  (reg_v),
    .o_lcd_data (data),
    .o_lcd_rs   (rs),
    .o_lcd_rw   (rw),
    .o_lcd_en   (en),
    .o_lcd_on   (on),
    .o_busy     (busy),
    .o_drop     (drop)
  );

  always @(negedge clk) if (drop === 1'b1) drop_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counts en=0 samples from now, then en=1 samples; returns at the first sample after the pulse.
  task automatic next_pulse(output int gap, output int width, output logic [7:0] d, output logic r);
    gap = 0;
    width = 0;
    while (en !== 1'b1 && gap < 200) begin gap++; @(negedge clk); end
    d = data;
    r = rs;
    while (en === 1'b1 && width < 200) begin width++; @(negedge clk); end
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy === 1'b1 && n < 300) begin n++; @(negedge clk); end
  endtask

  task automatic write(input logic [31:0] v);
    wr = 1'b1;
    reg_v = v;
    @(negedge clk);
    wr = 1'b0;
  endtask

  int gap, width, n, d0;
  logic [7:0] pd;
  logic pr;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_en", en, 0);
    chk("rst_data", data, 0);
    chk("rst_rs", rs, 0);
    chk("rst_rw", rw, 0);
    chk("rst_on", on, 0);
    chk("rst_drop", drop, 0);

    // Init: PWRUP(10)+SETUP(2) before first pulse; gaps HOLD+EXEC+SETUP, 12 after clear.
    rst_n = 1'b1;
    next_pulse(gap, width, pd, pr);
    chk("init0_gap", gap, 12); chk("init0_w", width, 3); chk("init0_d", pd, 8'h38); chk("init0_rs", pr, 0);
    next_pulse(gap, width, pd, pr);
    chk("init1_gap", gap, 8); chk("init1_w", width, 3); chk("init1_d", pd, 8'h0C);
    next_pulse(gap, width, pd, pr);
    chk("init2_gap", gap, 8); chk("init2_w", width, 3); chk("init2_d", pd, 8'h01);
    next_pulse(gap, width, pd, pr);
    chk("init3_gap", gap, 12); chk("init3_w", width, 3); chk("init3_d", pd, 8'h06);
    busy_len(n);
    chk("init_tail_busy", n, 6);
    chk("init_idle_busy", busy, 0);

    // IDLE write: EN 3 cycles after strobe, busy for 2+3+1+5 cycles.
    write(32'h8000_0241);
    chk("idle_on", on, 1);
    chk("idle_busy", busy, 1);
    next_pulse(gap, width, pd, pr);
    chk("idle_lat", gap + 1, 3); chk("idle_w", width, 3); chk("idle_d", pd, 8'h41); chk("idle_rs", pr, 1);
    busy_len(n);
    chk("idle_busy_total", 2 + 3 + n, 11);

    // Back-to-back writes both reach the bus, no drop.
    d0 = drop_cnt;
    write(32'h0000_0248);
    write(32'h0000_0249);
    chk("b2b_on", on, 0);
    next_pulse(gap, width, pd, pr);
    chk("b2b0_d", pd, 8'h48); chk("b2b0_rs", pr, 1);
    next_pulse(gap, width, pd, pr);
    chk("b2b1_gap", gap, 8); chk("b2b1_d", pd, 8'h49);
    busy_len(n);
    chk("b2b_tail", n, 6);
    chk("b2b_drops", drop_cnt - d0, 0);

    // Three writes: third dropped with a single-cycle pulse.
    d0 = drop_cnt;
    write(32'h0000_0250);
    write(32'h0000_0251);
    write(32'h0000_0252);
    next_pulse(gap, width, pd, pr);
    chk("tri0_d", pd, 8'h50);
    next_pulse(gap, width, pd, pr);
    chk("tri1_gap", gap, 8); chk("tri1_d", pd, 8'h51);
    busy_len(n);
    chk("tri_tail", n, 6);
    chk("tri_bus_last", data, 8'h51);
    chk("tri_drops", drop_cnt - d0, 1);

    // Home command uses the long wait; same data with RS=1 does not.
    write(32'h0000_0002);
    next_pulse(gap, width, pd, pr);
    chk("home_d", pd, 8'h02); chk("home_rs", pr, 0);
    busy_len(n);
    chk("home_exec", n - 1, 9);
    write(32'h0000_0202);
    next_pulse(gap, width, pd, pr);
    chk("data02_rs", pr, 1);
    busy_len(n);
    chk("data02_exec", n - 1, 5);

    // Reset during EN_HI: outputs clear without a clock edge, then init restarts.
    write(32'h8000_0241);
    n = 0;
    while (en !== 1'b1 && n < 20) begin n++; @(negedge clk); end
    chk("ab_en_hi", en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ab_en", en, 0);
    chk("ab_busy", busy, 1);
    chk("ab_data", data, 0);
    chk("ab_rs", rs, 0);
    chk("ab_on", on, 0);
    @(negedge clk);
    rst_n = 1'b1;
    next_pulse(gap, width, pd, pr);
    chk("reinit_gap", gap, 12); chk("reinit_d", pd, 8'h38);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
